c_merge4_sync: RTL and testbench

//  Clocked counterpart of the 4-way drive/free selector: merges four upstream drive/free

---
 rtl/c_ctrl_pkg.sv | 15 +
 rtl/c_rr_arb4.sv | 35 +++
 rtl/c_merge4_sync.sv | 116 +++++++++++
 tb/tb_c_merge4_sync.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/c_ctrl_pkg.sv
// Shared encodings and defaults for the drive/free selector family.
// Combinational definitions only; no latency and no backpressure.
// Every block that takes a port count defaults to C_NUM_PORTS.
package c_ctrl_pkg;

  localparam int C_NUM_PORTS = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FREE  = 2'd3
  } ctrlState_t;

endpackage

// File: rtl/c_rr_arb4.sv
// Round-robin pick: the first request at or after ptr, with wrap-around, wins.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when the grant is consumed.
module c_rr_arb4
  import c_ctrl_pkg::*;
#(
  parameter int NUM_PORTS = C_NUM_PORTS,
  parameter int PTR_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output logic                 vld
);

  localparam logic [NUM_PORTS-1:0] ONE = NUM_PORTS'(1);

  logic [NUM_PORTS-1:0] reqRot;
  logic [NUM_PORTS-1:0] gntRot;

  // Rotate so ptr sits at bit 0, keep the lowest set bit, then rotate back.
  always_comb begin
    reqRot = '0;
    gnt    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      reqRot[i] = req[(i + int'(ptr)) % NUM_PORTS];
    end
    gntRot = reqRot & (~reqRot + ONE);
    for (int i = 0; i < NUM_PORTS; i++) begin
      gnt[(i + int'(ptr)) % NUM_PORTS] = gntRot[i];
    end
    vld = |req;
  end

endmodule

// File: rtl/c_merge4_sync.sv
// Merges NUM_PORTS drive/free channels onto one downstream channel, granting one at a time by round-robin.
// Latency: i_drive to o_driveNext is 2 cycles; i_freeNext to o_free is 1 cycle.
// Backpressure: each port holds at most one pending request; repeat requests coalesce and raise o_err.
module c_merge4_sync
  import c_ctrl_pkg::*;
#(
  parameter int NUM_PORTS = C_NUM_PORTS
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NUM_PORTS-1:0] i_drive,
  output logic [NUM_PORTS-1:0] o_free,
  output logic                 o_driveNext,
  input  logic                 i_freeNext,
  output logic [NUM_PORTS-1:0] o_select,
  output logic                 o_busy,
  output logic                 o_err
);

  localparam int PTR_W = $clog2(NUM_PORTS);

  ctrlState_t           state;
  ctrlState_t           stateNxt;
  logic [NUM_PORTS-1:0] pending;
  logic [NUM_PORTS-1:0] pendingNxt;
  logic [NUM_PORTS-1:0] clrMask;
  logic [NUM_PORTS-1:0] arbGnt;
  logic [NUM_PORTS-1:0] selNxt;
  logic                 arbVld;
  logic [PTR_W-1:0]     rrPtr;
  logic [PTR_W-1:0]     rrPtrNxt;
  logic [PTR_W-1:0]     selIdx;
  logic                 freeExpected;
  logic                 errNxt;

  c_rr_arb4 #(
    .NUM_PORTS(NUM_PORTS),
    .PTR_W    (PTR_W)
  ) uArb (
    .req(pending),
    .ptr(rrPtr),
    .gnt(arbGnt),
    .vld(arbVld)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= stateNxt;
    end
  end

  // o_select doubles as the latched grant for the whole DRIVE..FREE span.
  always_comb begin
    stateNxt = state;
    selNxt   = o_select;
    case (state)
      ST_IDLE: begin
        if (arbVld) begin
          stateNxt = ST_DRIVE;
          selNxt   = arbGnt;
        end
      end
      ST_DRIVE: stateNxt = i_freeNext ? ST_FREE : ST_WAIT;
      ST_WAIT:  if (i_freeNext) stateNxt = ST_FREE;
      ST_FREE:  stateNxt = ST_IDLE;
      default:  stateNxt = ST_IDLE;
    endcase
    if (stateNxt == ST_IDLE) begin
      selNxt = '0;
    end
  end

  always_comb begin
    selIdx = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (o_select[k]) selIdx = PTR_W'(k);
    end
  end

  always_comb begin
    freeExpected = (state == ST_DRIVE) || (state == ST_WAIT);
    clrMask      = (freeExpected && i_freeNext) ? o_select : '0;
    // A fresh request landing on the clearing edge survives as a new request.
    pendingNxt   = (pending & ~clrMask) | i_drive;
    errNxt       = o_err
                 | (|(i_drive & pending & ~clrMask))
                 | (i_freeNext && !freeExpected);
    rrPtrNxt     = rrPtr;
    if (state == ST_FREE) begin
      rrPtrNxt = (selIdx == PTR_W'(NUM_PORTS - 1)) ? '0 : selIdx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending     <= '0;
      rrPtr       <= '0;
      o_err       <= 1'b0;
      o_select    <= '0;
      o_driveNext <= 1'b0;
      o_free      <= '0;
      o_busy      <= 1'b0;
    end else begin
      pending     <= pendingNxt;
      rrPtr       <= rrPtrNxt;
      o_err       <= errNxt;
      o_select    <= selNxt;
      o_driveNext <= (stateNxt == ST_DRIVE);
      o_free      <= (stateNxt == ST_FREE) ? selNxt : '0;
      o_busy      <= (stateNxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_c_merge4_sync.sv
// Randomized and directed stimulus for c_merge4_sync against a transaction-level reference model.
module tb_c_merge4_sync;

  localparam int N       = 4;
  localparam int P_IDLE  = 0;
  localparam int P_DRIVE = 1;
  localparam int P_WAIT  = 2;
  localparam int P_FREE  = 3;

  logic         clk = 1'b0;
  logic         rstn = 1'b1;
  logic [N-1:0] i_drive = '0;
  logic         i_freeNext = 1'b0;
  logic [N-1:0] o_free;
  logic         o_driveNext;
  logic [N-1:0] o_select;
  logic         o_busy;
  logic         o_err;

  int nChecks = 0;
  int nPass   = 0;

  int mPhase;
  int mPort;
  int mPtr;
  bit mPend[N];
  bit mErr;
  int freeLog[$];

  always #5 clk = ~clk;

  c_merge4_sync #(.NUM_PORTS(N)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .i_drive    (i_drive),
    .o_free     (o_free),
    .o_driveNext(o_driveNext),
    .i_freeNext (i_freeNext),
    .o_select   (o_select),
    .o_busy     (o_busy),
    .o_err      (o_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic modelReset();
    mPhase = P_IDLE;
    mPort  = -1;
    mPtr   = 0;
    mErr   = 1'b0;
    for (int k = 0; k < N; k++) mPend[k] = 1'b0;
  endtask

  // One clock edge of the reference behaviour, fed the inputs sampled at that edge.
  task automatic modelStep(input logic [N-1:0] drv, input logic fn);
    int pick;
    int clr;
    pick = -1;
    clr  = -1;
    if (mPhase == P_IDLE) begin
      for (int off = 0; off < N; off++) begin
        if (pick < 0 && mPend[(mPtr + off) % N]) pick = (mPtr + off) % N;
      end
    end
    if ((mPhase == P_DRIVE || mPhase == P_WAIT) && fn) clr = mPort;
    if (fn && (mPhase == P_IDLE || mPhase == P_FREE)) mErr = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (drv[k] && mPend[k] && k != clr) mErr = 1'b1;
    end
    for (int k = 0; k < N; k++) begin
      if (k == clr) mPend[k] = 1'b0;
      if (drv[k]) mPend[k] = 1'b1;
    end
    case (mPhase)
      P_IDLE: begin
        if (pick >= 0) begin
          mPort  = pick;
          mPhase = P_DRIVE;
        end
      end
      P_DRIVE, P_WAIT: mPhase = fn ? P_FREE : P_WAIT;
      default: begin
        mPtr   = (mPort + 1) % N;
        mPort  = -1;
        mPhase = P_IDLE;
      end
    endcase
  endtask

  task automatic compareAll();
    logic [N-1:0] eSel;
    eSel = '0;
    if (mPhase != P_IDLE) eSel[mPort] = 1'b1;
    chk("driveNext", o_driveNext, mPhase == P_DRIVE);
    chk("select", o_select, eSel);
    chk("free", o_free, (mPhase == P_FREE) ? eSel : '0);
    chk("busy", o_busy, mPhase != P_IDLE);
    chk("err", o_err, mErr);
  endtask

  task automatic step(input logic [N-1:0] drv, input logic fn);
    i_drive    = drv;
    i_freeNext = fn;
    @(posedge clk);
    modelStep(drv, fn);
    #1;
    i_drive    = '0;
    i_freeNext = 1'b0;
    compareAll();
    for (int k = 0; k < N; k++) begin
      if (o_free[k]) freeLog.push_back(k);
    end
  endtask

  // Reset held across exactly one rising edge; outputs must clear before that edge.
  task automatic doReset();
    i_drive    = '0;
    i_freeNext = 1'b0;
    rstn       = 1'b0;
    #1;
    modelReset();
    compareAll();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    freeLog.delete();
  endtask

  task automatic serveUntil(input int nFrees, input int budget);
    for (int c = 0; c < budget && freeLog.size() < nFrees; c++) begin
      step('0, o_driveNext);
    end
    chk("serveCount", freeLog.size(), nFrees);
  endtask

  initial begin
    logic [N-1:0] drv;
    #2;
    doReset();

    // Single request: latency and release.
    step(4'b0001, 1'b0);
    chk("t1DriveEarly", o_driveNext, 1'b0);
    step('0, 1'b0);
    chk("t1Drive", o_driveNext, 1'b1);
    chk("t1Select", o_select, 4'b0001);
    step('0, 1'b0);
    step('0, 1'b0);
    step('0, 1'b1);
    chk("t1Free", o_free, 4'b0001);
    step('0, 1'b0);
    chk("t1Busy", o_busy, 1'b0);

    // All four at once, freed in the DRIVE cycle.
    doReset();
    step(4'b1111, 1'b0);
    serveUntil(4, 40);
    for (int i = 0; i < 4 && i < freeLog.size(); i++) chk("t2Order", freeLog[i], i);
    chk("t2Err", o_err, 1'b0);
    freeLog.delete();
    step(4'b1001, 1'b0);
    serveUntil(1, 20);
    if (freeLog.size() > 0) chk("t2PtrWrap", freeLog[0], 0);

    // Fairness: ports 0 and 2 re-request right after each of their frees.
    doReset();
    step(4'b0101, 1'b0);
    for (int c = 0; c < 60 && freeLog.size() < 4; c++) begin
      drv = '0;
      drv[0] = o_free[0];
      drv[2] = o_free[2];
      step(drv, o_driveNext);
    end
    chk("t3Count", freeLog.size(), 4);
    for (int i = 0; i < 4 && i < freeLog.size(); i++) chk("t3Order", freeLog[i], (i % 2) * 2);
    chk("t3Err", o_err, 1'b0);

    // Free arriving in the DRIVE cycle.
    doReset();
    step(4'b0100, 1'b0);
    step('0, 1'b0);
    chk("t4Drive", o_driveNext, 1'b1);
    step('0, 1'b1);
    chk("t4Free", o_free, 4'b0100);
    chk("t4Err", o_err, 1'b0);

    // Stray free while idle.
    doReset();
    step('0, 1'b1);
    chk("t5aErr", o_err, 1'b1);
    chk("t5aFree", o_free, 4'b0000);

    // Duplicate request coalesces.
    doReset();
    step(4'b0010, 1'b0);
    step(4'b0010, 1'b0);
    chk("t5bErr", o_err, 1'b1);
    for (int c = 0; c < 14; c++) step('0, o_driveNext);
    chk("t5bGrants", freeLog.size(), 1);
    if (freeLog.size() > 0) chk("t5bPort", freeLog[0], 1);

    // Reset while waiting for the downstream free.
    doReset();
    step(4'b0001, 1'b0);
    step('0, 1'b0);
    step('0, 1'b0);
    chk("t6Wait", o_busy, 1'b1);
    doReset();
    chk("t6Select", o_select, 4'b0000);
    step('0, 1'b1);
    chk("t6Err", o_err, 1'b1);
    for (int c = 0; c < 4; c++) step('0, 1'b0);
    chk("t6NoFree", freeLog.size(), 0);

    // Random traffic against the model.
    doReset();
    for (int c = 0; c < 800; c++) begin
      drv = '0;
      for (int k = 0; k < N; k++) drv[k] = ($urandom_range(0, 5) == 0);
      step(drv, o_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0));
      if (c == 400) doReset();
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 500000", $time);
    $fatal(1);
  end

endmodule
